// File: rtl/rotation_aligner_if.sv
// Handshake bundle for the rotation aligner.
// The requester drives search inputs; the aligner returns status and result.
interface rotation_aligner_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] pattern;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    rot_amt;

  modport master (
    output start,
    output dir,
    output data_in,
    output pattern,
    input  busy,
    input  done,
    input  found,
    input  data_out,
    input  rot_amt
  );

  modport slave (
    input  start,
    input  dir,
    input  data_in,
    input  pattern,
    output busy,
    output done,
    output found,
    output data_out,
    output rot_amt
  );
endinterface

// File: rtl/rotation_aligner.sv
// Recovers word alignment by rotating one bit per cycle
// until the captured word matches the sync pattern.
module rotation_aligner #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  rotation_aligner_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    rot_q, rot_d;

  function automatic logic [WIDTH-1:0] rotl(
    input logic [WIDTH-1:0] w
  );
    return {w[WIDTH-2:0], w[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotr(
    input logic [WIDTH-1:0] w
  );
    return {w[0], w[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    orig_d  = orig_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    dout_d  = dout_q;
    rot_d   = rot_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.data_in;
          orig_d  = bus.data_in;
          pat_d   = bus.pattern;
          dir_d   = bus.dir;
          cnt_d   = '0;
          found_d = 1'b0;
          dout_d  = '0;
          rot_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (work_q == pat_q) begin
          found_d = 1'b1;
          dout_d  = work_q;
          rot_d   = cnt_q;
          state_d = DONE;
        end else if (cnt_q == CW'(WIDTH-1)) begin
          // last rotation tried: hand back the word as received
          found_d = 1'b0;
          dout_d  = orig_q;
          rot_d   = '0;
          state_d = DONE;
        end else begin
          work_d = dir_q ? rotr(work_q) : rotl(work_q);
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      orig_q  <= '0;
      pat_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      dout_q  <= '0;
      rot_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      orig_q  <= orig_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      dout_q  <= dout_d;
      rot_q   <= rot_d;
    end
  end

  assign bus.busy     = (state_q == SEARCH);
  assign bus.done     = (state_q == DONE);
  assign bus.found    = found_q;
  assign bus.data_out = dout_q;
  assign bus.rot_amt  = rot_q;
endmodule
